// File: rtl/y_pkg.sv
// Shared definitions for the Y SRAM write packer, memory wrapper and readback stages.
package y_pkg;

  localparam int Y_ADDR_W = 11;
  localparam int Y_WORD_W = 256;
  localparam int Y_ELEM_W = 16;
  localparam int Y_LANES  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    DONE = 2'd2
  } y_state_e;

endpackage

// File: rtl/y_write_packer.sv
// Packs a valid/ready stream of DATA_W-bit elements into LANES-wide words and
// writes them sequentially into the Y SRAM starting at a programmable base.
module y_write_packer
  import y_pkg::*;
#(
  parameter int DATA_W = Y_ELEM_W,
  parameter int LANES  = Y_LANES,
  parameter int ADDR_W = Y_ADDR_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     Y_WE,
  output logic [ADDR_W-1:0]        Y_WriteAddress,
  output logic [DATA_W*LANES-1:0]  Y_WriteBus,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W:0]          words_written
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0]   LAST_LANE = LW'(LANES - 1);
  // words_written saturates at 2^ADDR_W
  localparam logic [ADDR_W:0] WW_MAX    = {1'b1, {ADDR_W{1'b0}}};

  y_state_e state_q, state_d;

  logic [LW-1:0]            lane_cnt_q, lane_cnt_d;
  logic [DATA_W-1:0]        lane_buf_q [LANES];
  logic [ADDR_W-1:0]        wptr_q, wptr_d;
  logic [ADDR_W:0]          words_q, words_d;
  logic                     we_q, we_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W*LANES-1:0]  bus_q, bus_d;

  logic                     start_ok;
  logic                     accept;
  logic                     emit;
  logic [LANES-1:0]         lane_hit;
  logic [DATA_W*LANES-1:0]  word_asm;

  assign start_ok = (state_q == IDLE) && start;
  assign accept   = in_valid && in_ready;
  assign emit     = accept && ((lane_cnt_q == LAST_LANE) || in_last);

  // The word written on an emit includes the beat accepted in that same cycle,
  // so the final lane is taken straight from in_data rather than the buffer.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_hit[gi] = accept && (lane_cnt_q == LW'(gi));
    assign word_asm[gi*DATA_W +: DATA_W] = lane_hit[gi] ? in_data : lane_buf_q[gi];
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state: in_last moves to DONE in the same edge that emits the final word
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = PACK;
      PACK:    if (accept && in_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshake and status decode purely from state
  always_comb begin
    in_ready = (state_q == PACK);
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
  end

  // Datapath next-state: pointer, lane count, word counter and write port
  always_comb begin
    lane_cnt_d = lane_cnt_q;
    wptr_d     = wptr_q;
    words_d    = words_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    bus_d      = bus_q;
    if (start_ok) begin
      lane_cnt_d = '0;
      wptr_d     = base_addr;
      words_d    = '0;
    end else if (emit) begin
      we_d       = 1'b1;
      addr_d     = wptr_q;
      bus_d      = word_asm;
      wptr_d     = wptr_q + ADDR_W'(1);
      lane_cnt_d = '0;
      if (words_q != WW_MAX) words_d = words_q + (ADDR_W+1)'(1);
    end else if (accept) begin
      lane_cnt_d = lane_cnt_q + LW'(1);
    end
  end

  // Datapath registers; write address and bus hold their value between strobes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lane_cnt_q <= '0;
      wptr_q     <= '0;
      words_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      bus_q      <= '0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      wptr_q     <= wptr_d;
      words_q    <= words_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      bus_q      <= bus_d;
    end
  end

  // Lane buffer: cleared on start and after each emit so unfilled lanes read as zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < LANES; k++) lane_buf_q[k] <= '0;
    end else if (start_ok || emit) begin
      for (int k = 0; k < LANES; k++) lane_buf_q[k] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_hit[k]) lane_buf_q[k] <= in_data;
      end
    end
  end

  assign Y_WE           = we_q;
  assign Y_WriteAddress = addr_q;
  assign Y_WriteBus     = bus_q;
  assign words_written  = words_q;

endmodule

// File: tb/tb_y_write_packer.sv
// Directed bench for y_write_packer with a write scoreboard.
module tb_y_write_packer;

  localparam int DW = 16;
  localparam int NL = 16;
  localparam int AW = 11;
  localparam int WW = DW * NL;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic           in_last;
  logic           Y_WE;
  logic [AW-1:0]  Y_WriteAddress;
  logic [WW-1:0]  Y_WriteBus;
  logic           busy;
  logic           done;
  logic [AW:0]    words_written;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;
  int   wr_seen  = 0;
  int   done_seen = 0;

  y_write_packer #(.DATA_W(DW), .LANES(NL), .ADDR_W(AW)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .Y_WE           (Y_WE),
    .Y_WriteAddress (Y_WriteAddress),
    .Y_WriteBus     (Y_WriteBus),
    .busy           (busy),
    .done           (done),
    .words_written  (words_written)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
    vec_cnt++;
    assert (obs === expv) else begin
      miss_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected word
  always @(negedge clock) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      if (Y_WE === 1'b1) begin
        wr_seen++;
        chk("write_expected", WW'(exp_q.size() != 0), WW'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", WW'(Y_WriteAddress), WW'(e.addr));
          chk("wr_data", Y_WriteBus, e.data);
          chk("done_on_last_write", WW'(done), WW'(e.last));
          $display("write addr=%03h done=%0b data=%064h", Y_WriteAddress, done, Y_WriteBus);
        end
      end
      if (done === 1'b1) begin
        done_seen++;
        chk("done_with_we", WW'(Y_WE), WW'(1));
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] b);
    start = 1'b1;
    base_addr = b;
    @(posedge clock); #1;
    start = 1'b0;
    chk("ready_after_start", WW'(in_ready), WW'(1));
    chk("busy_after_start", WW'(busy), WW'(1));
  endtask

  // mode 0: values i+1, mode 1: 0xAAAA+i, otherwise random
  task automatic run_xfer(input logic [AW-1:0] b, input int n, input int mode,
                          input bit rand_valid, input bit glitch);
    logic [DW-1:0] vals[$];
    logic [WW-1:0] word;
    exp_t e;
    int nwords, wr0, dn0, i, cyc, exp_ww;
    bit acc;
    for (int j = 0; j < n; j++) begin
      case (mode)
        0:       vals.push_back(DW'(j + 1));
        1:       vals.push_back(16'hAAAA + DW'(j));
        default: vals.push_back(DW'($urandom));
      endcase
    end
    nwords = (n + NL - 1) / NL;
    for (int w = 0; w < nwords; w++) begin
      word = '0;
      for (int k = 0; k < NL; k++)
        if (w * NL + k < n) word[k*DW +: DW] = vals[w * NL + k];
      e.addr = b + AW'(w);
      e.data = word;
      e.last = (w == nwords - 1);
      exp_q.push_back(e);
    end
    wr0 = wr_seen;
    dn0 = done_seen;
    do_start(b);
    i = 0;
    cyc = 0;
    while (i < n) begin
      start = 1'b0;
      if (glitch && i == n / 2) begin
        start = 1'b1;
        base_addr = 11'h123;
      end
      if (rand_valid && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        in_last  = 1'b1;
      end else begin
        in_valid = 1'b1;
        in_data  = vals[i];
        in_last  = (i == n - 1);
        if (!rand_valid) chk("ready_stream", WW'(in_ready), WW'(1));
      end
      acc = in_valid && in_ready;
      @(posedge clock); #1;
      if (acc) i++;
      cyc++;
      if (cyc > 4 * n + 100) begin
        vec_cnt++;
        miss_cnt++;
        $error("FAIL timeout observed=%0d beats expected=%0d beats", i, n);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = glitch;  // a start during DONE must be ignored
    base_addr = 11'h155;
    @(negedge clock);
    @(posedge clock); #1;
    start = 1'b0;
    chk("idle_after_done", WW'(busy), WW'(0));
    chk("write_count", WW'(wr_seen - wr0), WW'(nwords));
    chk("done_count", WW'(done_seen - dn0), WW'(1));
    chk("scoreboard_empty", WW'(exp_q.size()), WW'(0));
    exp_ww = (nwords > 2048) ? 2048 : nwords;
    chk("words_written", WW'(words_written), WW'(exp_ww));
    $display("transfer base=%03h beats=%0d words=%0d words_written=%0d", b, n, nwords, words_written);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    WW'(Y_WE), WW'(0));
    chk({tag, "_addr"},  WW'(Y_WriteAddress), WW'(0));
    chk({tag, "_bus"},   Y_WriteBus, WW'(0));
    chk({tag, "_words"}, WW'(words_written), WW'(0));
    chk({tag, "_busy"},  WW'(busy), WW'(0));
    chk({tag, "_ready"}, WW'(in_ready), WW'(0));
    chk({tag, "_done"},  WW'(done), WW'(0));
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;

    // full word, values 1..16
    run_xfer(11'h010, 16, 0, 1'b0, 1'b0);
    // streaming three words
    run_xfer(11'h020, 48, 2, 1'b0, 1'b0);
    // partial flush
    run_xfer(11'h030, 5, 1, 1'b0, 1'b0);
    // address wrap
    run_xfer(11'h7FF, 32, 2, 1'b0, 1'b0);

    // in_valid while idle is not consumed
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    in_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("idle_not_ready", WW'(in_ready), WW'(0));
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    // backpressure plus start pulses during PACK and DONE
    run_xfer(11'h100, 40, 2, 1'b1, 1'b1);

    // reset in the middle of a word
    do_start(11'h040);
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(16'h7000 + k);
      in_last  = 1'b0;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("midreset_no_write", WW'(exp_q.size()), WW'(0));
    run_xfer(11'h200, 16, 2, 1'b0, 1'b0);

    // words_written saturation
    run_xfer(11'h000, 2049 * NL, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
